// File: rtl/vga_timing_gen_if.sv
//------------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel tick enable and all registered timing outputs of the
// VGA timing generator. The generator uses the master view; the downstream
// pixel pipeline observes everything through the slave view.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if #(
  parameter int H_W = 11,
  parameter int V_W = 10
);
  logic           pix_ce;
  logic           h_sync;
  logic           v_sync;
  logic           display_en;
  logic           fetch_en;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           line_start;
  logic           frame_start;

  modport master (
    input  pix_ce,
    output h_sync, v_sync, display_en, fetch_en,
    output h_count, v_count, line_start, frame_start
  );

  modport slave (
    input  pix_ce,
    input  h_sync, v_sync, display_en, fetch_en,
    input  h_count, v_count, line_start, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator. A pixel counter pair (hc, vc) walks the
// full raster on every pix_ce tick; all decodes (syncs, display window,
// prefetch window, line/frame strobes) are registered from the pre-increment
// counter values so every output is mutually aligned, one tick behind hc/vc.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int H_W      = 11,
  parameter int V_W      = 10,
  parameter int PREFETCH = 2
) (
  input  wire logic        clk_in,
  input  wire logic        reset_n,
  vga_timing_gen_if.master bus
);

  // Raster geometry
  localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HS_START = H_ACTIVE + H_FP;
  localparam int c_HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int c_VS_START = V_ACTIVE + V_FP;
  localparam int c_VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [H_W-1:0] c_H_LAST = H_W'(c_H_TOTAL - 1);
  localparam logic [V_W-1:0] c_V_LAST = V_W'(c_V_TOTAL - 1);

  // The fetch counter pair starts PREFETCH pixels into line 0. PREFETCH is
  // smaller than the blanking width, so it never reaches past the first line.
  localparam logic [H_W-1:0] c_FH_RESET = H_W'(PREFETCH);

  // Reject configurations the counters or the prefetch window cannot hold
  if ((c_H_TOTAL - 1) >= (64'd1 << H_W)) begin : g_chk_hw
    $error("vga_timing_gen: H_W too narrow for H_TOTAL-1");
  end
  if ((c_V_TOTAL - 1) >= (64'd1 << V_W)) begin : g_chk_vw
    $error("vga_timing_gen: V_W too narrow for V_TOTAL-1");
  end
  if ((PREFETCH < 0) || (PREFETCH >= (H_FP + H_SYNC + H_BP))) begin : g_chk_pf
    $error("vga_timing_gen: PREFETCH must satisfy 0 <= PREFETCH < H_FP+H_SYNC+H_BP");
  end

  // Raster position counters and the look-ahead pair used for fetch_en
  logic [H_W-1:0] r_hc;
  logic [V_W-1:0] r_vc;
  logic [H_W-1:0] r_fhc;
  logic [V_W-1:0] r_fvc;

  // Registered outputs
  logic           r_h_sync;
  logic           r_v_sync;
  logic           r_display_en;
  logic           r_fetch_en;
  logic [H_W-1:0] r_h_count;
  logic [V_W-1:0] r_v_count;
  logic           r_line_start;
  logic           r_frame_start;

  // Next-state and decode wires
  logic [H_W-1:0] w_hc_next;
  logic [V_W-1:0] w_vc_next;
  logic [H_W-1:0] w_fhc_next;
  logic [V_W-1:0] w_fvc_next;
  logic           w_h_last;
  logic           w_v_last;
  logic           w_fh_last;
  logic           w_fv_last;
  logic           w_disp;
  logic           w_fetch;
  logic           w_hs_act;
  logic           w_vs_act;
  logic           w_hc_zero;
  logic           w_vc_zero;

  // Counter wrap logic for both the display and the look-ahead position
  always_comb begin
    w_h_last   = (r_hc  == c_H_LAST);
    w_v_last   = (r_vc  == c_V_LAST);
    w_fh_last  = (r_fhc == c_H_LAST);
    w_fv_last  = (r_fvc == c_V_LAST);

    w_hc_next  = w_h_last ? '0 : r_hc + 1'b1;
    w_vc_next  = r_vc;
    if (w_h_last) begin
      w_vc_next = w_v_last ? '0 : r_vc + 1'b1;
    end

    w_fhc_next = w_fh_last ? '0 : r_fhc + 1'b1;
    w_fvc_next = r_fvc;
    if (w_fh_last) begin
      w_fvc_next = w_fv_last ? '0 : r_fvc + 1'b1;
    end
  end

  // Region decodes from the pre-increment position; v_sync follows vc, which
  // only changes at the line wrap, so it switches with the hc=0 pixel
  always_comb begin
    w_disp    = (32'(r_hc)  < H_ACTIVE) && (32'(r_vc)  < V_ACTIVE);
    w_fetch   = (32'(r_fhc) < H_ACTIVE) && (32'(r_fvc) < V_ACTIVE);
    w_hs_act  = (32'(r_hc) >= c_HS_START) && (32'(r_hc) < c_HS_END);
    w_vs_act  = (32'(r_vc) >= c_VS_START) && (32'(r_vc) < c_VS_END);
    w_hc_zero = (r_hc == '0);
    w_vc_zero = (r_vc == '0);
  end

  // Position counters advance once per pixel tick
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hc  <= '0;
      r_vc  <= '0;
      r_fhc <= c_FH_RESET;
      r_fvc <= '0;
    end else if (bus.pix_ce) begin
      r_hc  <= w_hc_next;
      r_vc  <= w_vc_next;
      r_fhc <= w_fhc_next;
      r_fvc <= w_fvc_next;
    end
  end

  // Timing outputs load on each pixel tick and hold between ticks
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_h_count    <= '0;
      r_v_count    <= '0;
      r_display_en <= 1'b0;
      r_fetch_en   <= 1'b0;
      r_h_sync     <= ~H_POL;
      r_v_sync     <= ~V_POL;
    end else if (bus.pix_ce) begin
      r_h_count    <= r_hc;
      r_v_count    <= r_vc;
      r_display_en <= w_disp;
      r_fetch_en   <= w_fetch;
      r_h_sync     <= w_hs_act ? H_POL : ~H_POL;
      r_v_sync     <= w_vs_act ? V_POL : ~V_POL;
    end
  end

  // Strobes pulse for one clock after a tick that loads hc=0; cleared on any
  // other edge so they never stretch across an idle pix_ce stretch
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= bus.pix_ce && w_hc_zero;
      r_frame_start <= bus.pix_ce && w_hc_zero && w_vc_zero;
    end
  end

  assign bus.h_sync      = r_h_sync;
  assign bus.v_sync      = r_v_sync;
  assign bus.display_en  = r_display_en;
  assign bus.fetch_en    = r_fetch_en;
  assign bus.h_count     = r_h_count;
  assign bus.v_count     = r_v_count;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 800x600 sync block.
- All horizontal/vertical timings, sync polarities and counter widths are parameters.
- Adds a pixel clock-enable for divided pixel rates, line/frame start strobes, and a prefetch window so SRAM pixel fetch leads the display.
- Sits between the clock/PLL wrapper and the pattern/SRAM pixel pipeline.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1, h_sync asserted level (1 = active-high, 0 = active-low)
- V_POL, 1, v_sync asserted level
- H_W, 11, h_count width; must hold H_TOTAL-1
- V_W, 10, v_count width; must hold V_TOTAL-1
- PREFETCH, 2, pixel ticks by which fetch_en leads display_en; must satisfy 0 <= PREFETCH < H_FP+H_SYNC+H_BP

Ports:
- clk_in  input  1  pixel/system clock
- reset_n  input  1  asynchronous active-low reset
- pix_ce  input  1  pixel tick enable; tie high for one pixel per clock
- h_sync  output  1  horizontal sync at H_POL level during the sync region
- v_sync  output  1  vertical sync at V_POL level during the sync region
- display_en  output  1  current pixel is visible
- fetch_en  output  1  pixel PREFETCH ticks ahead is visible
- h_count  output  H_W  horizontal position of current pixel
- v_count  output  V_W  vertical position of current pixel
- line_start  output  1  one-clock strobe when h_count becomes 0
- frame_start  output  1  one-clock strobe when (h_count, v_count) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666).
- Internal counters hc and vc:
  - hc runs 0..H_TOTAL-1; vc runs 0..V_TOTAL-1.
  - Both advance only on clk_in edges with pix_ce=1.
  - At hc = H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc = H_TOTAL-1 and vc = V_TOTAL-1, both wrap to 0.
  - No extra or skipped counts at any wrap.
- Output registers, updated on each pix_ce edge from the pre-increment (hc, vc):
  - h_count/v_count load hc/vc.
  - display_en = hc < H_ACTIVE && vc < V_ACTIVE.
  - h_sync is asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; otherwise it sits at the idle level ~H_POL.
  - v_sync is asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; otherwise idle ~V_POL.
  - h_sync is decoded per pixel. v_sync is decoded per line, changing with the line's hc=0 pixel.
- Alignment: all outputs are mutually aligned, with one pix_ce tick latency from the counters. When pix_ce=0, every output holds its value except the strobes.
- fetch_en:
  - Evaluates display_en at (hc, vc) advanced by PREFETCH ticks, including line and frame wrap.
  - It rises PREFETCH ticks before display_en and falls PREFETCH ticks before display_en falls.
  - PREFETCH = 0 makes fetch_en identical to display_en.
- Strobes:
  - line_start = 1 for exactly one clk_in cycle after any pix_ce edge that loaded h_count = 0.
  - frame_start = 1 for exactly one clk_in cycle after the pix_ce edge that loaded (0,0).
  - Both strobes clear on the next clk_in edge regardless of pix_ce.
- Reset (reset_n=0, asynchronous, any time including mid-line or mid-sync):
  - hc = vc = 0; h_count = v_count = 0.
  - display_en = fetch_en = line_start = frame_start = 0.
  - h_sync = ~H_POL, v_sync = ~V_POL.
- After reset release, the first pix_ce edge outputs pixel (0,0) with display_en=1, line_start=1, frame_start=1.
- No state machine beyond the counters. All decodes are registered, with no combinational outputs.
- Elaboration fails if H_W/V_W are too narrow or the PREFETCH constraint is violated.

Test Plan:
- Small config (H 8/2/2/2 → H_TOTAL 14; V 4/1/1/1 → V_TOTAL 7; PREFETCH 2; pix_ce=1), reset then run 3 frames → h_count cycles 0..13; v_count increments at each h wrap and wraps 6→0; frame_start period is exactly 98 clocks; line_start period is exactly 14 clocks.
- Same config → display_en high exactly for h_count 0..7 with v_count 0..3; h_sync asserted for h_count 10..11; v_sync asserted for v_count 5 across all 14 pixels of that line; polarity flip (H_POL=0) inverts h_sync only.
- Same config → fetch_en rises at h_count 12 of lines 6,0,1,2 (2 ticks before display_en of the next line), falls at h_count 6 of lines 0..3; stays low through lines 3→4 wrap.
- pix_ce asserted every 3rd clock → counts and sync advance once per 3 clocks; line_start/frame_start each last exactly 1 clock; other outputs hold between ticks.
- Assert reset_n low mid-h_sync at (11,5) → all outputs go to their reset values immediately, without waiting for a clock edge; after release, the first pix_ce yields (0,0) with display_en=1 and frame_start=1.
- Default 800x600 params → H_TOTAL 1040, V_TOTAL 666; h_sync asserted h_count 856..975; v_sync asserted v_count 637..642; 692,640 clocks per frame.
